// File: rtl/ysyx_041514_bim_table.sv
// Bimodal branch predictor table: 2^BIM_IDX_W two-bit saturating counters indexed by PC.
// A power-up sweep sets every entry to INIT_CNT. Both ports stall until the sweep completes.
module ysyx_041514_bim_table #(
    parameter int         BIM_IDX_W = 7,
    parameter int         PC_W      = 64,
    parameter logic [1:0] INIT_CNT  = 2'b01
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bim_lookup_valid_i,
    input  logic [PC_W-1:0] bim_lookup_pc_i,
    output logic            bim_lookup_ready_o,
    output logic            bim_lookup_valid_o,
    output logic [1:0]      bim_lookup_cnt_o,
    output logic            bim_lookup_taken_o,
    input  logic            bim_upd_valid_i,
    input  logic [PC_W-1:0] bim_upd_pc_i,
    input  logic            bim_upd_taken_i,
    output logic            bim_upd_ready_o,
    output logic            bim_init_done_o
);

    localparam int ENTRIES = 1 << BIM_IDX_W;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               state_r, state_nxt_s;
    logic [BIM_IDX_W-1:0] ptr_r, ptr_nxt_s;
    logic                 run_r;

    logic [1:0]           tbl_r [ENTRIES];

    logic                 u1_v_r;
    logic [BIM_IDX_W-1:0] u1_idx_r;
    logic                 u1_taken_r;
    logic [1:0]           u1_rd_s, u1_new_s;

    logic                 lk_acc_s, upd_acc_s;
    logic [BIM_IDX_W-1:0] lk_idx_s, upd_idx_s;
    logic [1:0]           lk_val_s;

    logic                 wr_en_s;
    logic [BIM_IDX_W-1:0] wr_idx_s;
    logic [1:0]           wr_data_s;

    logic                 valid_r, taken_r;
    logic [1:0]           cnt_r;
    logic                 unused_pc_s;

    // Saturating two-bit counter step; never wraps in either direction.
    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        end else begin
            res = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
        end
        return res;
    endfunction

    assign lk_idx_s    = bim_lookup_pc_i[BIM_IDX_W+1:2];
    assign upd_idx_s   = bim_upd_pc_i[BIM_IDX_W+1:2];
    assign unused_pc_s = ^{bim_lookup_pc_i[PC_W-1:BIM_IDX_W+2], bim_lookup_pc_i[1:0],
                           bim_upd_pc_i[PC_W-1:BIM_IDX_W+2], bim_upd_pc_i[1:0]};

    assign lk_acc_s  = bim_lookup_valid_i & run_r;
    assign upd_acc_s = bim_upd_valid_i & run_r;

    // Next-state logic: sweep one entry per cycle, then stay in RUN.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        case (state_r)
            ST_INIT: begin
                ptr_nxt_s = ptr_r + {{(BIM_IDX_W-1){1'b0}}, 1'b1};
                if (ptr_r == {BIM_IDX_W{1'b1}}) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_INIT;
        endcase
    end

    // State register, sweep pointer and registered ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_INIT;
            ptr_r   <= {BIM_IDX_W{1'b0}};
            run_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            run_r   <= (state_nxt_s == ST_RUN);
        end
    end

    // U1 read-modify-write, with lookup forwarding from the in-flight update.
    always_comb begin
        u1_rd_s  = tbl_r[u1_idx_r];
        u1_new_s = sat_step(u1_rd_s, u1_taken_r);
        if (u1_v_r && (u1_idx_r == lk_idx_s)) begin
            lk_val_s = u1_new_s;
        end else begin
            lk_val_s = tbl_r[lk_idx_s];
        end
    end

    // Single table write port: the init sweep owns it in INIT, U1 in RUN.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_idx_s  = u1_idx_r;
        wr_data_s = u1_new_s;
        if (state_r == ST_INIT) begin
            wr_en_s   = ~rst;
            wr_idx_s  = ptr_r;
            wr_data_s = INIT_CNT;
        end else begin
            wr_en_s   = u1_v_r & ~rst;
        end
    end

    // Counter storage; contents are defined by the init sweep, not by reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            tbl_r[wr_idx_s] <= wr_data_s;
        end
    end

    // U1 stage capture; reset drops any in-flight update.
    always_ff @(posedge clk) begin
        if (rst) begin
            u1_v_r     <= 1'b0;
            u1_idx_r   <= {BIM_IDX_W{1'b0}};
            u1_taken_r <= 1'b0;
        end else begin
            u1_v_r <= upd_acc_s;
            if (upd_acc_s) begin
                u1_idx_r   <= upd_idx_s;
                u1_taken_r <= bim_upd_taken_i;
            end
        end
    end

    // Lookup result registers; count and taken hold between accepts.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            cnt_r   <= 2'b00;
            taken_r <= 1'b0;
        end else begin
            valid_r <= lk_acc_s;
            if (lk_acc_s) begin
                cnt_r   <= lk_val_s;
                taken_r <= lk_val_s[1];
            end
        end
    end

    assign bim_lookup_ready_o = run_r;
    assign bim_upd_ready_o    = run_r;
    assign bim_init_done_o    = run_r;
    assign bim_lookup_valid_o = valid_r;
    assign bim_lookup_cnt_o   = cnt_r;
    assign bim_lookup_taken_o = taken_r;

endmodule

// File: tb/tb_ysyx_041514_bim_table.sv
// Randomized bench for the bimodal table against an array-of-integers predictor model.
module tb_ysyx_041514_bim_table;

    logic        clk;
    logic        rst;
    logic        bim_lookup_valid_i;
    logic [63:0] bim_lookup_pc_i;
    logic        bim_lookup_ready_o;
    logic        bim_lookup_valid_o;
    logic [1:0]  bim_lookup_cnt_o;
    logic        bim_lookup_taken_o;
    logic        bim_upd_valid_i;
    logic [63:0] bim_upd_pc_i;
    logic        bim_upd_taken_i;
    logic        bim_upd_ready_o;
    logic        bim_init_done_o;

    int total = 0;
    int bad   = 0;
    int mdl [128];
    int edges_since_rst = 0;
    int held_cnt = 0;

    ysyx_041514_bim_table dut (
        .clk                (clk),
        .rst                (rst),
        .bim_lookup_valid_i (bim_lookup_valid_i),
        .bim_lookup_pc_i    (bim_lookup_pc_i),
        .bim_lookup_ready_o (bim_lookup_ready_o),
        .bim_lookup_valid_o (bim_lookup_valid_o),
        .bim_lookup_cnt_o   (bim_lookup_cnt_o),
        .bim_lookup_taken_o (bim_lookup_taken_o),
        .bim_upd_valid_i    (bim_upd_valid_i),
        .bim_upd_pc_i       (bim_upd_pc_i),
        .bim_upd_taken_i    (bim_upd_taken_i),
        .bim_upd_ready_o    (bim_upd_ready_o),
        .bim_init_done_o    (bim_init_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [63:0] pc);
        return int'((pc >> 2) % 64'd128);
    endfunction

    task automatic check_ready;
        logic run_exp;
        run_exp = (edges_since_rst >= 128);
        check("lookup_ready", {63'd0, bim_lookup_ready_o}, {63'd0, run_exp});
        check("upd_ready", {63'd0, bim_upd_ready_o}, {63'd0, run_exp});
        check("init_done", {63'd0, bim_init_done_o}, {63'd0, run_exp});
    endtask

    // One clock with the given requests; the model applies accepted updates at once,
    // so a lookup in the same cycle sees the old value and any later one the new.
    task automatic cycle(input logic lv, input logic [63:0] lpc,
                         input logic uv, input logic [63:0] upc, input logic ut);
        logic run_now;
        logic exp_v;
        int   u;
        run_now = (edges_since_rst >= 128);
        bim_lookup_valid_i = lv;
        bim_lookup_pc_i    = lpc;
        bim_upd_valid_i    = uv;
        bim_upd_pc_i       = upc;
        bim_upd_taken_i    = ut;
        exp_v = lv && run_now;
        if (exp_v) held_cnt = mdl[idx_of(lpc)];
        if (uv && run_now) begin
            u = idx_of(upc);
            if (ut) mdl[u] = (mdl[u] >= 3) ? 3 : mdl[u] + 1;
            else    mdl[u] = (mdl[u] <= 0) ? 0 : mdl[u] - 1;
        end
        @(posedge clk);
        #1;
        edges_since_rst++;
        check("lookup_valid", {63'd0, bim_lookup_valid_o}, {63'd0, exp_v});
        check("lookup_cnt", {62'd0, bim_lookup_cnt_o}, 64'(held_cnt));
        check("lookup_taken", {63'd0, bim_lookup_taken_o}, {63'd0, held_cnt >= 2});
        check_ready();
    endtask

    task automatic do_reset(input logic noisy);
        rst = 1'b1;
        bim_lookup_valid_i = noisy;
        bim_lookup_pc_i    = {$urandom, $urandom};
        bim_upd_valid_i    = noisy;
        bim_upd_pc_i       = {$urandom, $urandom};
        bim_upd_taken_i    = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        edges_since_rst = 0;
        held_cnt = 0;
        for (int i = 0; i < 128; i++) mdl[i] = 1;
        check("rst_valid", {63'd0, bim_lookup_valid_o}, 64'd0);
        check("rst_cnt", {62'd0, bim_lookup_cnt_o}, 64'd0);
        check_ready();
    endtask

    task automatic sweep(input logic noisy);
        for (int i = 0; i < 128; i++) begin
            if (noisy) cycle($urandom_range(0, 1), {$urandom, $urandom},
                             $urandom_range(0, 1), {$urandom, $urandom}, $urandom_range(0, 1));
            else       cycle(1'b0, 64'd0, 1'b0, 64'd0, 1'b0);
        end
    endtask

    initial begin
        logic [63:0] pc;
        rst = 1'b1;
        bim_lookup_valid_i = 1'b0;
        bim_lookup_pc_i    = 64'd0;
        bim_upd_valid_i    = 1'b0;
        bim_upd_pc_i       = 64'd0;
        bim_upd_taken_i    = 1'b0;

        // Power-up sweep with idle inputs, then lookups of fresh entries.
        do_reset(1'b0);
        sweep(1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, {$urandom, $urandom}, 1'b0, 64'd0, 1'b0);

        // Saturation at the top.
        pc = 64'h8000_0010;
        for (int i = 0; i < 3; i++) cycle(1'b0, 64'd0, 1'b1, pc, 1'b1);
        cycle(1'b1, pc, 1'b0, 64'd0, 1'b0);

        // Saturation at the bottom on idx 5.
        pc = 64'd5 << 2;
        for (int i = 0; i < 4; i++) cycle(1'b0, 64'd0, 1'b1, pc, 1'b0);
        cycle(1'b1, pc, 1'b0, 64'd0, 1'b0);

        // Same-cycle lookup sees the old value; the following one is forwarded.
        pc = 64'd9 << 2;
        cycle(1'b1, pc, 1'b1, pc, 1'b1);
        cycle(1'b1, pc | 64'hF000_0000_0000_0003, 1'b0, 64'd0, 1'b0);

        // Train idx 3, leave an update in flight, then reset mid-run.
        pc = 64'd3 << 2;
        cycle(1'b0, 64'd0, 1'b1, pc, 1'b1);
        cycle(1'b0, 64'd0, 1'b1, pc, 1'b1);
        cycle(1'b1, pc, 1'b1, pc, 1'b1);
        do_reset(1'b1);
        // Requests during the sweep are ignored.
        sweep(1'b1);
        cycle(1'b1, pc, 1'b0, 64'd0, 1'b0);
        for (int i = 0; i < 128; i++) cycle(1'b1, 64'(i) << 2, 1'b0, 64'd0, 1'b0);

        // Random traffic on a few entries with aliasing upper PC bits.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 1), {$urandom, 20'd0, 7'($urandom_range(0, 3)), 2'($urandom)},
                  $urandom_range(0, 1), {$urandom, 20'd0, 7'($urandom_range(0, 3)), 2'($urandom)},
                  $urandom_range(0, 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
